// File: rtl/fusioncap_pkg.sv
// rtl/fusioncap_pkg.sv - shared constants, state type, default weights and output saturation
// Weight/bias arrays hold Q8.8 defaults; deployment replaces them with trained values.
package fusioncap_pkg;

   localparam int N_IN      = 10;
   localparam int N_OUT_MAX = 4;
   localparam int DW        = 16;
   localparam int FRAC      = 8;
   localparam int ACC_W     = 40;
   localparam int KW        = $clog2(N_IN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } mac_state_t;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   // Identity weights: neuron n forwards x[n] and adds its own index as bias.
   localparam logic signed [DW-1:0] W_DEF [N_OUT_MAX][N_IN] = '{
      '{16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
      '{16'sd0, 16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
      '{16'sd0, 16'sd0, 16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
      '{16'sd0, 16'sd0, 16'sd0, 16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}
   };

   localparam logic signed [DW-1:0] BIAS_DEF [N_OUT_MAX] = '{16'sd0, 16'sd256, 16'sd512, 16'sd768};

   // Rescale by FRAC (floor), clamp to the DW range, then optional ReLU.
   function automatic logic signed [DW-1:0] sat_relu(input logic signed [ACC_W-1:0] acc,
                                                     input logic relu);
      logic signed [ACC_W-1:0] r;
      r = acc >>> FRAC;
      if (relu && (r < 0))
         return '0;
      if (r > SAT_HI)
         r = SAT_HI;
      else if (r < SAT_LO)
         r = SAT_LO;
      return $signed(r[DW-1:0]);
   endfunction

endpackage

// File: rtl/fusioncap_weight_rom.sv
// rtl/fusioncap_weight_rom.sv - combinational weight/bias lookup for the dense MAC
// Isolated so a registered BRAM can replace it later.
module fusioncap_weight_rom
   import fusioncap_pkg::*;
#(
   parameter int NW = 2
)(
   input  logic [NW-1:0]        i_n,
   input  logic [KW-1:0]        i_k,
   output logic signed [DW-1:0] o_w,
   output logic signed [DW-1:0] o_bias
);

   always_comb begin
      o_w    = '0;
      o_bias = '0;
      if (int'(i_n) < N_OUT_MAX) begin
         o_bias = BIAS_DEF[i_n];
         if (int'(i_k) < N_IN)
            o_w = W_DEF[i_n][i_k];
      end
   end

endmodule

// File: rtl/fusioncap_dense_mac.sv
// rtl/fusioncap_dense_mac.sv - serial fully-connected layer over the 10-sample fusion window
// One MAC per cycle, N_IN cycles per neuron plus one output cycle.
module fusioncap_dense_mac
   import fusioncap_pkg::*;
#(
   parameter int N_OUT = N_OUT_MAX,
   parameter bit RELU  = 1'b1,
   localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] x0,
   input  logic signed [DW-1:0] x1,
   input  logic signed [DW-1:0] x2,
   input  logic signed [DW-1:0] x3,
   input  logic signed [DW-1:0] x4,
   input  logic signed [DW-1:0] x5,
   input  logic signed [DW-1:0] x6,
   input  logic signed [DW-1:0] x7,
   input  logic signed [DW-1:0] x8,
   input  logic signed [DW-1:0] x9,
   output logic signed [DW-1:0] odata,
   output logic                 ovalid,
   output logic [NW-1:0]        oidx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

   mac_state_t                r_state, w_state_nxt;
   logic signed [DW-1:0]      r_x [N_IN];
   logic signed [DW-1:0]      w_xin [N_IN];
   logic [NW-1:0]             r_n;
   logic [KW-1:0]             r_k;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [DW-1:0]      r_odata;
   logic [NW-1:0]             r_oidx;
   logic                      r_ovalid, r_busy, r_done;

   logic [NW-1:0]             w_rom_n;
   logic signed [DW-1:0]      w_w, w_bias;
   logic signed [2*DW-1:0]    w_prod;
   logic signed [ACC_W-1:0]   w_bias_acc;

   assign w_xin = '{x0, x1, x2, x3, x4, x5, x6, x7, x8, x9};

   // Bias lookahead: neuron 0 at capture, neuron n+1 while emitting neuron n.
   assign w_rom_n = (r_state == ST_IDLE) ? '0 :
                    (r_state == ST_OUT)  ? NW'(r_n + 1'b1) : r_n;

   fusioncap_weight_rom #(.NW(NW)) u_rom (
      .i_n    (w_rom_n),
      .i_k    (r_k),
      .o_w    (w_w),
      .o_bias (w_bias)
   );

   assign w_prod     = r_x[r_k] * w_w;
   assign w_bias_acc = ACC_W'(w_bias) <<< FRAC;

   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_MAC;
            ST_MAC:  if (r_k == K_LAST) w_state_nxt = ST_OUT;
            ST_OUT:  w_state_nxt = (r_n == N_LAST) ? ST_IDLE : ST_MAC;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N_IN; i++)
            r_x[i] <= '0;
         r_n      <= '0;
         r_k      <= '0;
         r_acc    <= '0;
         r_odata  <= '0;
         r_oidx   <= '0;
         r_ovalid <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_ovalid <= 1'b0;
         r_done   <= 1'b0;
         if (start) begin
            case (r_state)
               ST_IDLE: begin
                  if (in_valid) begin
                     for (int i = 0; i < N_IN; i++)
                        r_x[i] <= w_xin[i];
                     r_n    <= '0;
                     r_k    <= '0;
                     r_acc  <= w_bias_acc;
                     r_busy <= 1'b1;
                  end
               end
               ST_MAC: begin
                  r_acc <= r_acc + ACC_W'(w_prod);
                  r_k   <= r_k + 1'b1;
               end
               ST_OUT: begin
                  r_odata  <= sat_relu(r_acc, RELU);
                  r_oidx   <= r_n;
                  r_ovalid <= 1'b1;
                  if (r_n == N_LAST) begin
                     r_done <= 1'b1;
                     r_busy <= 1'b0;
                  end else begin
                     r_n   <= r_n + 1'b1;
                     r_k   <= '0;
                     r_acc <= w_bias_acc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign odata  = r_odata;
   assign oidx   = r_oidx;
   assign ovalid = r_ovalid;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_fusioncap_dense_mac.sv
// tb/tb_fusioncap_dense_mac.sv - self-checking bench for fusioncap_dense_mac
// Two instances (ReLU on/off) share every input.
module tb_fusioncap_dense_mac;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic signed [15:0] x_in [10];

   logic signed [15:0] odata_r, odata_l;
   logic [1:0]         oidx_r, oidx_l;
   logic               ovalid_r, ovalid_l, busy_r, busy_l, done_r, done_l;

   int total = 0;
   int bad = 0;
   int res_r [4];
   int res_l [4];

   always #5 clk = ~clk;

   fusioncap_dense_mac #(.N_OUT(4), .RELU(1'b1)) u_relu (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]), .x4(x_in[4]),
      .x5(x_in[5]), .x6(x_in[6]), .x7(x_in[7]), .x8(x_in[8]), .x9(x_in[9]),
      .odata(odata_r), .ovalid(ovalid_r), .oidx(oidx_r), .busy(busy_r), .done(done_r)
   );

   fusioncap_dense_mac #(.N_OUT(4), .RELU(1'b0)) u_lin (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]), .x4(x_in[4]),
      .x5(x_in[5]), .x6(x_in[6]), .x7(x_in[7]), .x8(x_in[8]), .x9(x_in[9]),
      .odata(odata_l), .ovalid(ovalid_l), .oidx(oidx_l), .busy(busy_l), .done(done_l)
   );

   function automatic longint w_ref(input int n, input int k);
      return (n == k) ? 256 : 0;
   endfunction

   // Real-valued neuron: floor((bias + sum x*w) / 256), clamped, optional ReLU.
   function automatic int model(input int xs[10], input int n, input bit relu);
      longint acc;
      longint r;
      acc = longint'(n * 256) * 256;
      for (int k = 0; k < 10; k++)
         acc += longint'(xs[k]) * w_ref(n, k);
      r = acc >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return int'(r);
   endfunction

   task automatic run_window(input string name, input int xs[10], input int xmid[10],
                             input bit freeze, input bit hold);
      int got;
      int exp_cyc;
      int er, el;
      got = 0;
      for (int k = 0; k < 10; k++) x_in[k] = 16'(xs[k]);
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 60 && got < 4; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (cyc == 1) begin
            total++;
            if (busy_r !== 1'b1) begin
               bad++;
               $display("FAIL %s busy_after_capture got=%b exp=1", name, busy_r);
            end
            if (!hold) in_valid = 1'b0;
         end
         if (freeze && cyc == 27) begin
            total++;
            if (busy_r !== 1'b1) begin
               bad++;
               $display("FAIL %s busy_during_freeze got=%b exp=1", name, busy_r);
            end
         end
         exp_cyc = (got + 1) * 11 + ((freeze && got >= 2) ? 5 : 0);
         if (ovalid_r === 1'b1) begin
            er = model(xs, got, 1'b1);
            el = model(xs, got, 1'b0);
            total++;
            if (cyc != exp_cyc) begin
               bad++;
               $display("FAIL %s strobe_time n=%0d got=%0d exp=%0d", name, got, cyc, exp_cyc);
            end
            total++;
            if (oidx_r !== 2'(got)) begin
               bad++;
               $display("FAIL %s oidx got=%0d exp=%0d", name, oidx_r, got);
            end
            total++;
            if (int'(odata_r) !== er) begin
               bad++;
               $display("FAIL %s odata_relu n=%0d got=%0d exp=%0d", name, got, odata_r, er);
            end
            total++;
            if (ovalid_l !== 1'b1 || int'(odata_l) !== el) begin
               bad++;
               $display("FAIL %s odata_lin n=%0d got=%0d/%b exp=%0d/1", name, got, odata_l, ovalid_l, el);
            end
            total++;
            if (done_r !== (got == 3) || done_l !== (got == 3)) begin
               bad++;
               $display("FAIL %s done n=%0d got=%b/%b exp=%b", name, got, done_r, done_l, got == 3);
            end
            res_r[got] = int'(odata_r);
            res_l[got] = int'(odata_l);
            got++;
            if (got == 4) begin
               total++;
               if (busy_r !== 1'b0 || busy_l !== 1'b0) begin
                  bad++;
                  $display("FAIL %s busy_after_done got=%b/%b exp=0", name, busy_r, busy_l);
               end
            end
         end else begin
            if (cyc == exp_cyc) begin
               total++;
               bad++;
               $display("FAIL %s missing_strobe n=%0d got=0 exp=1 at cycle %0d", name, got, cyc);
            end
            if (done_r !== 1'b0) begin
               total++;
               bad++;
               $display("FAIL %s stray_done got=%b exp=0 at cycle %0d", name, done_r, cyc);
            end
         end
         if (cyc == 3)
            for (int k = 0; k < 10; k++) x_in[k] = 16'(xmid[k]);
         if (freeze && cyc == 24) start = 1'b0;
         if (freeze && cyc == 29) start = 1'b1;
      end
      total++;
      if (got != 4) begin
         bad++;
         $display("FAIL %s strobe_count got=%0d exp=4", name, got);
      end
   endtask

   task automatic check_zero(input string name);
      total++;
      if (odata_r !== 16'sd0 || oidx_r !== 2'd0 || ovalid_r !== 1'b0 || busy_r !== 1'b0 ||
          done_r !== 1'b0 || odata_l !== 16'sd0 || ovalid_l !== 1'b0 || busy_l !== 1'b0) begin
         bad++;
         $display("FAIL %s outputs got=%0d,%0d,%b,%b,%b lin=%0d,%b,%b exp=all 0", name,
                  odata_r, oidx_r, ovalid_r, busy_r, done_r, odata_l, ovalid_l, busy_l);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) x_in[k] = 16'(k + 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_zero("reset_hold");
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (busy_r !== 1'b1 || busy_l !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_capture busy got=%b/%b exp=1", busy_r, busy_l);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_zero("reset_midrun");
   endtask

   task automatic test_abort();
      for (int k = 0; k < 10; k++) x_in[k] = 16'(300 + k);
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (cyc == 1) in_valid = 1'b0;
         if (cyc == 15) begin
            check_zero("abort");
            rst = 1'b1;
         end
         if (cyc > 15 && (ovalid_r !== 1'b0 || busy_r !== 1'b0)) begin
            total++;
            bad++;
            $display("FAIL abort_activity ovalid=%b busy=%b exp=0 at cycle %0d", ovalid_r, busy_r, cyc);
         end
         if (cyc == 14) rst = 1'b0;
      end
   endtask

   task automatic test_identity();
      int xs[10];
      int exp_v[4];
      xs = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000};
      exp_v = '{100, 456, 812, 1168};
      run_window("identity", xs, xs, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         total++;
         if (res_r[n] !== exp_v[n] || res_l[n] !== exp_v[n]) begin
            bad++;
            $display("FAIL identity_const n=%0d got=%0d/%0d exp=%0d", n, res_r[n], res_l[n], exp_v[n]);
         end
      end
   endtask

   task automatic test_saturation();
      int xs[10];
      xs = '{-32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0};
      run_window("saturation", xs, xs, 1'b0, 1'b0);
      total++;
      if (res_l[1] !== 32767 || res_r[1] !== 32767) begin
         bad++;
         $display("FAIL sat_high got=%0d/%0d exp=32767", res_r[1], res_l[1]);
      end
      total++;
      if (res_l[0] !== -32768 || res_r[0] !== 0) begin
         bad++;
         $display("FAIL sat_low got relu=%0d lin=%0d exp 0/-32768", res_r[0], res_l[0]);
      end
   endtask

   task automatic test_relu();
      int xs[10];
      xs = '{-500, 0, -1000, 0, 0, 0, 0, 0, 0, 0};
      run_window("relu", xs, xs, 1'b0, 1'b0);
      total++;
      if (res_r[0] !== 0 || res_l[0] !== -500 || res_r[2] !== 0 || res_l[2] !== -488) begin
         bad++;
         $display("FAIL relu_const got=%0d,%0d,%0d,%0d exp=0,-500,0,-488",
                  res_r[0], res_l[0], res_r[2], res_l[2]);
      end
   endtask

   task automatic test_freeze();
      int xs[10];
      xs = '{-7, 1234, -2222, 31000, 5, 6, 7, 8, 9, 10};
      run_window("freeze", xs, xs, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int xa[10];
      int xb[10];
      for (int k = 0; k < 10; k++) begin
         xa[k] = 11 * k - 40;
         xb[k] = 1000 - 90 * k;
      end
      run_window("b2b_first", xa, xb, 1'b0, 1'b1);
      run_window("b2b_recapture", xb, xa, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int xs[10];
      int xm[10];
      for (int t = 0; t < 5; t++) begin
         for (int k = 0; k < 10; k++) begin
            xs[k] = int'($urandom_range(65535, 0)) - 32768;
            xm[k] = int'($urandom_range(65535, 0)) - 32768;
         end
         run_window("random", xs, xm, 1'($urandom_range(1, 0)), 1'b0);
      end
   endtask

   initial begin
      for (int k = 0; k < 10; k++) x_in[k] = '0;
      test_reset();
      test_abort();
      test_identity();
      test_saturation();
      test_relu();
      test_freeze();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
